// File: rtl/ray_scheduler.sv
// Frame-level ray scheduler: walks the pixel raster, issues one ray per sphere to the
// intersection unit and emits the nearest hit per pixel. Optional watchdog: RTRT_TIMEOUT_EN.
module ray_scheduler #(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int N_SPHERES = 4,
    parameter int FOCAL     = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [47:0] i_cam,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic [3:0]  o_sph_idx,
    input  logic [63:0] i_sph_data,
    output logic        o_rsi_enable,
    output logic [47:0] o_rsi_p0,
    output logic [47:0] o_rsi_p1,
    output logic [63:0] o_rsi_sphere,
    output logic        o_rsi_bounded,
    output logic [3:0]  o_rsi_threshold,
    input  logic        i_rsi_ready,
    input  logic        i_rsi_collide,
    input  logic [47:0] i_rsi_pint0,
    output logic        o_pix_valid,
    input  logic        i_pix_ready,
    output logic [9:0]  o_pix_x,
    output logic [8:0]  o_pix_y,
    output logic        o_pix_hit,
    output logic [3:0]  o_pix_sphere,
    output logic [35:0] o_pix_depth,
    output logic        o_timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ISSUE, S_WAIT, S_ACCUM, S_EMIT, S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [47:0] r_cam;
    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic [3:0]  r_idx;
    logic [47:0] r_p0;
    logic [47:0] r_p1;
    logic [63:0] r_sphere;
    logic [7:0]  r_wait_cnt;
    logic        r_res_hit;
    logic [47:0] r_res_pint;
    logic [35:0] r_best_d;
    logic [3:0]  r_best_idx;
    logic        r_best_hit;

    logic        w_last_px;
    logic        w_last_sph;
    logic        w_wait_ready;
    logic        w_wait_expire;
    logic [47:0] w_p1;
    logic [15:0] w_off_x;
    logic [15:0] w_off_y;
    logic [33:0] w_sq [3];
    logic [35:0] w_dist;

    assign w_last_px  = (r_x == 10'(H_RES - 1)) && (r_y == 9'(V_RES - 1));
    assign w_last_sph = (r_idx == 4'(N_SPHERES - 1));

    // The first WAIT cycle has r_wait_cnt == 0, so a ready left over from the previous ray is ignored.
    assign w_wait_ready = (r_state == S_WAIT) && (r_wait_cnt != 8'd0) && i_rsi_ready;

    assign w_off_x = 16'(r_x) - 16'(H_RES / 2);
    assign w_off_y = 16'(r_y) - 16'(V_RES / 2);
    assign w_p1    = {r_cam[47:32] + w_off_x,
                      r_cam[31:16] + w_off_y,
                      r_cam[15:0]  + 16'(FOCAL)};

    // Squared distance from camera to the intersection point, one axis per slice.
    for (genvar gi = 0; gi < 3; gi++) begin : g_axis
        logic signed [16:0] w_diff;
        logic signed [33:0] w_diff_ext;
        assign w_diff     = $signed({r_res_pint[16*gi+15], r_res_pint[16*gi +: 16]})
                          - $signed({r_cam[16*gi+15], r_cam[16*gi +: 16]});
        assign w_diff_ext = {{17{w_diff[16]}}, w_diff};
        assign w_sq[gi]   = $unsigned(w_diff_ext * w_diff_ext);
    end

    assign w_dist = {2'b00, w_sq[0]} + {2'b00, w_sq[1]} + {2'b00, w_sq[2]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = S_SETUP;
            S_SETUP: w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT:  if (w_wait_ready || w_wait_expire) w_state_next = S_ACCUM;
            S_ACCUM: w_state_next = w_last_sph ? S_EMIT : S_SETUP;
            S_EMIT:  if (i_pix_ready) w_state_next = w_last_px ? S_DONE : S_SETUP;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cam      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_idx      <= '0;
            r_p0       <= '0;
            r_p1       <= '0;
            r_sphere   <= '0;
            r_wait_cnt <= '0;
            r_res_hit  <= 1'b0;
            r_res_pint <= '0;
            r_best_d   <= '0;
            r_best_idx <= '0;
            r_best_hit <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cam      <= i_cam;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_idx      <= '0;
                        r_best_d   <= '1;
                        r_best_idx <= '0;
                        r_best_hit <= 1'b0;
                    end
                end
                S_SETUP: begin
                    r_p0       <= r_cam;
                    r_p1       <= w_p1;
                    r_sphere   <= i_sph_data;
                    r_wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (r_wait_cnt != 8'hFF) begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                    if (w_wait_ready) begin
                        r_res_hit  <= i_rsi_collide;
                        r_res_pint <= i_rsi_pint0;
                    end else if (w_wait_expire) begin
                        r_res_hit  <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    // Strict compare: an equal distance keeps the earlier sphere.
                    if (r_res_hit && (w_dist < r_best_d)) begin
                        r_best_d   <= w_dist;
                        r_best_idx <= r_idx;
                        r_best_hit <= 1'b1;
                    end
                    if (!w_last_sph) begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                S_EMIT: begin
                    if (i_pix_ready) begin
                        r_idx      <= '0;
                        r_best_d   <= '1;
                        r_best_idx <= '0;
                        r_best_hit <= 1'b0;
                        if (r_x == 10'(H_RES - 1)) begin
                            r_x <= '0;
                            r_y <= r_y + 9'd1;
                        end else begin
                            r_x <= r_x + 10'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RTRT_TIMEOUT_EN
    logic r_timeout_err;

    assign w_wait_expire = (r_state == S_WAIT) && (r_wait_cnt == 8'hFF) && !i_rsi_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_timeout_err <= 1'b0;
        end else if (w_wait_expire) begin
            r_timeout_err <= 1'b1;
        end
    end

    assign o_timeout_err = r_timeout_err;
`else
    assign w_wait_expire = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

    assign o_busy          = (r_state != S_IDLE);
    assign o_frame_done    = (r_state == S_DONE);
    assign o_rsi_enable    = (r_state == S_ISSUE);
    assign o_pix_valid     = (r_state == S_EMIT);
    assign o_sph_idx       = r_idx;
    assign o_rsi_p0        = r_p0;
    assign o_rsi_p1        = r_p1;
    assign o_rsi_sphere    = r_sphere;
    assign o_rsi_bounded   = 1'b0;
    assign o_rsi_threshold = 4'd1;
    assign o_pix_x         = r_x;
    assign o_pix_y         = r_y;
    assign o_pix_hit       = r_best_hit;
    assign o_pix_sphere    = r_best_idx;
    assign o_pix_depth     = r_best_d;

endmodule

// File: doc/ray_scheduler.md
RAY_SCHEDULER -- requirements
Module: ray_scheduler

Interface
REQ-001 H_RES, 640: pixels per row.
REQ-002 V_RES, 480: rows per frame.
REQ-003 N_SPHERES, 4: spheres tested per pixel, 1..16.
REQ-004 FOCAL, 256: image-plane z offset from camera.
REQ-005 CLK  in  1  sole clock, rising edge.
REQ-006 RESET  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse that begins a frame.
REQ-008 cam  in  3x16 signed  camera position, sampled on accepted start.
REQ-009 busy  out  1  high from accepted start until frame_done.
REQ-010 frame_done  out  1  one-cycle pulse after the last pixel handshake.
REQ-011 sph_idx  out  4  sphere table index; sph_data  in  4x16  {x,y,z,r}, combinational, valid the same cycle.
REQ-012 rsi_enable  out  1  one-cycle start pulse to the intersection unit.
REQ-013 rsi_p0, rsi_p1  out  3x16 each  ray origin and ray target; rsi_sphere  out  4x16  registered copy of sph_data.
REQ-014 rsi_bounded  out  1, tied 0; rsi_threshold  out  4, tied 4'd1.
REQ-015 rsi_ready, rsi_collide  in  1 each; rsi_pint0  in  3x16 signed  nearest intersection point.
REQ-016 pix_valid  out  1; pix_ready  in  1: pixel output handshake.
REQ-017 pix_x  out  10, pix_y  out  9, pix_hit  out  1, pix_sphere  out  4, pix_depth  out  36 unsigned.
REQ-018 timeout_err  out  1  sticky watchdog flag.

Function
REQ-019 FSM states: IDLE, SETUP, ISSUE, WAIT, ACCUM, EMIT, DONE.
REQ-020 IDLE: start=1 latches cam, clears x, y, idx, goes to SETUP; start outside IDLE is ignored.
REQ-021 SETUP: rsi_p0=cam; rsi_p1=cam+{x-H_RES/2, y-V_RES/2, FOCAL}, mod 2^16; rsi_sphere=sph_data[idx]; next state ISSUE.
REQ-022 ISSUE: rsi_enable=1 for exactly one cycle; next state WAIT; rsi_p0, rsi_p1 and rsi_sphere hold stable until the next SETUP.
REQ-023 WAIT ignores rsi_ready in its first cycle and then advances to ACCUM on the first cycle rsi_ready=1.
REQ-024 ACCUM, if rsi_collide=1: d=sum over axes of (pint0-cam)^2, 17-bit signed difference, 36-bit unsigned sum.
REQ-025 ACCUM updates the best hit only when d < best_d (strict), so ties keep the lower idx; best_d initializes to all-ones per pixel.
REQ-026 ACCUM: idx<N_SPHERES-1 -> idx+1, go to SETUP; otherwise go to EMIT.
REQ-027 EMIT: pix_valid=1 with outputs stable until pix_ready=1; on handshake, x increments, wrapping at H_RES-1 to 0 with y+1, and the state goes to SETUP.
REQ-028 Handshake on pixel (H_RES-1, V_RES-1) goes to DONE; DONE pulses frame_done, clears busy, returns to IDLE.
REQ-029 pix_hit=0 -> pix_sphere=0 and pix_depth=all-ones.
REQ-030 Latency per pixel without stall: N_SPHERES*(3+intersector latency)+1 cycles.

Reset
REQ-031 RESET asserted, including mid-frame, immediately forces IDLE; all outputs go to 0 except rsi_threshold=1; the in-flight frame is abandoned without frame_done.
REQ-032 After RESET deasserts, the block accepts only a new start; stale rsi_ready is ignored outside WAIT.

Configuration
REQ-033 RTRT_TIMEOUT_EN defined: WAIT exceeding 255 cycles treats the result as no collision, sets timeout_err, continues; timeout_err clears only on RESET.
REQ-034 RTRT_TIMEOUT_EN undefined: WAIT has no limit; timeout_err is tied 0.

Verification
REQ-035 H_RES=4, V_RES=2, N_SPHERES=1, cam=0, intersector model always misses -> 8 pixels in raster order, all pix_hit=0, then a single frame_done.
REQ-036 Two spheres, model returns pint0 (0,0,10) for idx0 and (0,0,5) for idx1 -> pix_hit=1, pix_sphere=1, pix_depth=25.
REQ-037 Both spheres return d=100 -> pix_sphere=0 (tie keeps the lower index).
REQ-038 pix_ready held low 20 cycles -> pix_* stable, no rsi_enable, no x advance.
REQ-039 RESET pulsed during WAIT of pixel (2,1) -> next cycle busy=0, rsi_enable=0, pix_valid=0; a new start begins at (0,0).
REQ-040 With RTRT_TIMEOUT_EN, rsi_ready never rises -> after 256 WAIT cycles the pixel emits pix_hit=0, timeout_err=1 until RESET.
